// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port memory bus arbiter: FSM encoding,
// burst counter width and the saturating counter helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arbState_t;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_SAT = 4'd15;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational winner selection between two requesters with a bounded
// burst for the current owner and alternation out of IDLE.
module arb_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic             [1:0] state,
    input  logic                   lastOwner,
    input  logic       [CNT_W-1:0] cnt,
    input  logic                   req0,
    input  logic                   req1,
    output logic                   winValid,
    output logic                   win
);

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

    logic own;
    logic reqOwn;
    logic reqOther;

    assign own      = (state == OWN1);
    assign reqOwn   = own ? req1 : req0;
    assign reqOther = own ? req0 : req1;

    always_comb begin
        winValid = 1'b0;
        win      = 1'b0;
        if (state == OWN0 || state == OWN1) begin
            // The owner keeps the bus until its burst is used up and the other side waits.
            if (reqOwn && (!reqOther || cnt < BURST_LIM)) begin
                winValid = 1'b1;
                win      = own;
            end else if (reqOther) begin
                winValid = 1'b1;
                win      = !own;
            end
        end else begin
            if (req0 && req1) begin
                winValid = 1'b1;
                win      = !lastOwner;
            end else if (req0) begin
                winValid = 1'b1;
                win      = 1'b0;
            end else if (req1) begin
                winValid = 1'b1;
                win      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter in front of a synchronous single-port memory:
// grants one command per clock and routes read data back to its issuer.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int AW        = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [3:0]    we0,
    input  logic [AW-1:0] addr0,
    input  logic [31:0]   wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic [3:0]    we1,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [31:0]   rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [1:0]    dbgState
);

    // Handshake: a command transfers in any cycle where req_x and gnt_x are both
    // high; gnt_x is combinational from req_x, and rvalid_x follows a read by one clk.

    arbState_t        state, stateNext;
    logic             lastOwner, lastOwnerNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             pendValid, pendValidNext;
    logic             pendTag, pendTagNext;

    logic winValidRaw;
    logic winValid;
    logic win;

    arb_pick #(
        .BURST_MAX(BURST_MAX)
    ) uPick (
        .state    (state),
        .lastOwner(lastOwner),
        .cnt      (cnt),
        .req0     (req0),
        .req1     (req1),
        .winValid (winValidRaw),
        .win      (win)
    );

    assign winValid = winValidRaw && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lastOwner <= 1'b1;
            cnt       <= '0;
            pendValid <= 1'b0;
            pendTag   <= 1'b0;
        end else begin
            state     <= stateNext;
            lastOwner <= lastOwnerNext;
            cnt       <= cntNext;
            pendValid <= pendValidNext;
            pendTag   <= pendTagNext;
        end
    end

    always_comb begin
        stateNext     = IDLE;
        lastOwnerNext = lastOwner;
        cntNext       = cnt;
        pendValidNext = 1'b0;
        pendTagNext   = pendTag;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 4'b0000;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (winValid) begin
            gnt0          = !win;
            gnt1          = win;
            mem_en        = 1'b1;
            mem_we        = win ? we1 : we0;
            mem_addr      = win ? addr1 : addr0;
            mem_wdata     = win ? wdata1 : wdata0;
            stateNext     = win ? OWN1 : OWN0;
            lastOwnerNext = win;
            cntNext       = (state == (win ? OWN1 : OWN0)) ? satInc(cnt) : 4'd1;
            pendValidNext = (mem_we == 4'b0000);
            pendTagNext   = win;
        end
    end

    assign rvalid0  = pendValid && !pendTag;
    assign rvalid1  = pendValid && pendTag;
    assign rdata    = pendValid ? mem_rdata : 32'd0;
    assign dbgState = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (burst 4 and burst 1) share stimulus
// and are checked every cycle against a behavioural arbitration model.
module tb_mem_bus_arbiter;

    localparam int AW    = 11;
    localparam int DEPTH = 1 << AW;
    localparam int NINST = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0, req1;
    logic [3:0]    we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;

    logic          gnt0W[NINST];
    logic          gnt1W[NINST];
    logic          rv0W[NINST];
    logic          rv1W[NINST];
    logic [31:0]   rdataW[NINST];
    logic          memEnW[NINST];
    logic [3:0]    memWeW[NINST];
    logic [AW-1:0] memAddrW[NINST];
    logic [31:0]   memWdataW[NINST];
    logic [31:0]   memRdataW[NINST];
    logic [1:0]    dbgW[NINST];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.BURST_MAX(4), .AW(AW)) dutA (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0W[0]), .rvalid0(rv0W[0]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1W[0]), .rvalid1(rv1W[0]),
        .rdata(rdataW[0]), .mem_en(memEnW[0]), .mem_we(memWeW[0]), .mem_addr(memAddrW[0]),
        .mem_wdata(memWdataW[0]), .mem_rdata(memRdataW[0]), .dbgState(dbgW[0])
    );

    mem_bus_arbiter #(.BURST_MAX(1), .AW(AW)) dutB (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0W[1]), .rvalid0(rv0W[1]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1W[1]), .rvalid1(rv1W[1]),
        .rdata(rdataW[1]), .mem_en(memEnW[1]), .mem_we(memWeW[1]), .mem_addr(memAddrW[1]),
        .mem_wdata(memWdataW[1]), .mem_rdata(memRdataW[1]), .dbgState(dbgW[1])
    );

    function automatic logic [31:0] initWord(input logic [AW-1:0] a);
        return {16'hC0DE, 16'(a)};
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Memory behind each instance, driven only by that instance's bus outputs.
    logic [31:0] physMem[NINST][DEPTH];
    bit          physValid[NINST][DEPTH];

    always @(posedge clk) begin
        for (int k = 0; k < NINST; k++) begin
            if (memEnW[k]) begin
                if (memWeW[k] == 4'b0000) begin
                    memRdataW[k] <= physValid[k][memAddrW[k]] ? physMem[k][memAddrW[k]] : initWord(memAddrW[k]);
                end else begin
                    physMem[k][memAddrW[k]]   <= mergeBytes(physValid[k][memAddrW[k]] ? physMem[k][memAddrW[k]]
                                                            : initWord(memAddrW[k]), memWdataW[k], memWeW[k]);
                    physValid[k][memAddrW[k]] <= 1'b1;
                end
            end
        end
    end

    // Reference model: who holds the bus, how long, who was served last, and what memory holds.
    int          mOwner[NINST];
    int          mStreak[NINST];
    int          mLast[NINST];
    bit          mPend[NINST];
    int          mPendTag[NINST];
    int          expW[NINST];
    logic [31:0] refMem[NINST][DEPTH];
    bit          refValid[NINST][DEPTH];
    logic [31:0] expQ0[$];
    logic [31:0] expQ1[$];

    function automatic int burstOf(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic resetModel(input int k);
        mOwner[k]   = -1;
        mStreak[k]  = 0;
        mLast[k]    = 1;
        mPend[k]    = 1'b0;
        mPendTag[k] = 0;
        if (k == 0) expQ0.delete(); else expQ1.delete();
    endtask

    function automatic logic [31:0] peekExp(input int k);
        if (k == 0) return (expQ0.size() > 0) ? expQ0[0] : 32'hBAD0BAD0;
        return (expQ1.size() > 0) ? expQ1[0] : 32'hBAD0BAD0;
    endfunction

    function automatic int pickWinner(input int k);
        int o;
        bit rOwn, rOther;
        if (mOwner[k] < 0) begin
            if (req0 && req1) return 1 - mLast[k];
            if (req0) return 0;
            if (req1) return 1;
            return -1;
        end
        o      = mOwner[k];
        rOwn   = (o == 1) ? req1 : req0;
        rOther = (o == 1) ? req0 : req1;
        if (rOwn && (!rOther || mStreak[k] < burstOf(k))) return o;
        if (rOther) return 1 - o;
        return -1;
    endfunction

    task automatic checkNow();
        for (int k = 0; k < NINST; k++) begin
            int w;
            bit rv;
            logic [3:0] ew;
            logic [AW-1:0] ea;
            logic [31:0] ed;
            w = rst ? -1 : pickWinner(k);
            expW[k] = w;
            ew = (w == 0) ? we0 : (w == 1) ? we1 : 4'd0;
            ea = (w == 0) ? addr0 : (w == 1) ? addr1 : '0;
            ed = (w == 0) ? wdata0 : (w == 1) ? wdata1 : 32'd0;
            rv = mPend[k] && !rst;
            checkEq($sformatf("gnt0_%0d", k), gnt0W[k], w == 0);
            checkEq($sformatf("gnt1_%0d", k), gnt1W[k], w == 1);
            checkEq($sformatf("gntBoth_%0d", k), gnt0W[k] & gnt1W[k], 0);
            checkEq($sformatf("memEn_%0d", k), memEnW[k], w >= 0);
            checkEq($sformatf("memWe_%0d", k), memWeW[k], ew);
            checkEq($sformatf("memAddr_%0d", k), memAddrW[k], ea);
            checkEq($sformatf("memWdata_%0d", k), memWdataW[k], ed);
            checkEq($sformatf("rvalid0_%0d", k), rv0W[k], rv && mPendTag[k] == 0);
            checkEq($sformatf("rvalid1_%0d", k), rv1W[k], rv && mPendTag[k] == 1);
            checkEq($sformatf("rdata_%0d", k), rdataW[k], rv ? peekExp(k) : 32'd0);
            checkEq($sformatf("state_%0d", k), dbgW[k], rst ? 0 : mOwner[k] + 1);
        end
    endtask

    task automatic commit();
        for (int k = 0; k < NINST; k++) begin
            int w;
            logic [AW-1:0] a;
            w = expW[k];
            if (mPend[k]) begin
                if (k == 0) void'(expQ0.pop_front()); else void'(expQ1.pop_front());
                mPend[k] = 1'b0;
            end
            if (rst) begin
                resetModel(k);
            end else if (w >= 0) begin
                mStreak[k] = (w == mOwner[k]) ? ((mStreak[k] < 15) ? mStreak[k] + 1 : 15) : 1;
                mOwner[k]  = w;
                mLast[k]   = w;
                a = (w == 0) ? addr0 : addr1;
                if (((w == 0) ? we0 : we1) == 4'b0000) begin
                    if (k == 0) expQ0.push_back(refValid[k][a] ? refMem[k][a] : initWord(a));
                    else        expQ1.push_back(refValid[k][a] ? refMem[k][a] : initWord(a));
                    mPend[k]    = 1'b1;
                    mPendTag[k] = w;
                end else begin
                    refMem[k][a]   = mergeBytes(refValid[k][a] ? refMem[k][a] : initWord(a),
                                                (w == 0) ? wdata0 : wdata1, (w == 0) ? we0 : we1);
                    refValid[k][a] = 1'b1;
                end
            end else begin
                mOwner[k] = -1;
            end
        end
    endtask

    task automatic tickCheck();
        #1;
        checkNow();
    endtask

    task automatic tickAdvance();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic tick();
        tickCheck();
        tickAdvance();
    endtask

    task automatic drive0(input logic r, input logic [3:0] w, input logic [AW-1:0] a, input logic [31:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic [3:0] w, input logic [AW-1:0] a, input logic [31:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int waitCnt;
        bit seen1;
        drive0(1'b0, 4'd0, '0, 32'd0);
        drive1(1'b0, 4'd0, '0, 32'd0);
        for (int k = 0; k < NINST; k++) resetModel(k);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single requester streaming reads of preloaded words.
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, 4'd0, AW'(16 + i), $urandom);
            tick();
        end
        drive0(1'b0, 4'd0, '0, 32'd0);
        tick();

        // Continuous contention from reset: burst-4 and burst-1 grant patterns.
        resetPulse();
        drive0(1'b1, 4'd0, 11'h014, 32'd0);
        drive1(1'b1, 4'd0, 11'h015, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tickCheck();
            checkEq("pattern4", gnt1W[0], (i / 4) % 2);
            checkEq("pattern1", gnt1W[1], i % 2);
            checkEq("noIdle", memEnW[0] & memEnW[1], 1);
            tickAdvance();
        end
        drive0(1'b0, 4'd0, '0, 32'd0);
        drive1(1'b0, 4'd0, '0, 32'd0);
        tick();
        tick();

        // Partial write from requester 1, then read-back by requester 0.
        drive1(1'b1, 4'b0011, 11'h7FF, 32'hDEADBEEF);
        tickCheck();
        checkEq("partialWe", memWeW[0], 4'b0011);
        tickAdvance();
        drive1(1'b0, 4'd0, '0, 32'd0);
        drive0(1'b1, 4'd0, 11'h7FF, 32'd0);
        tick();
        drive0(1'b0, 4'd0, '0, 32'd0);
        tickCheck();
        checkEq("mergedRead", rdataW[0], 32'hC0DEBEEF);
        checkEq("noRvalid1", rv1W[0], 0);
        tickAdvance();

        // Asynchronous reset in the cycle after a read grant.
        drive0(1'b1, 4'd0, 11'h011, 32'd0);
        tick();
        tickCheck();
        #2;
        rst = 1'b1;
        for (int k = 0; k < NINST; k++) resetModel(k);
        #1;
        checkNow();
        checkEq("rstRvalid0", rv0W[0], 0);
        tickAdvance();
        tick();
        rst = 1'b0;
        drive1(1'b1, 4'd0, 11'h012, 32'd0);
        tickCheck();
        checkEq("firstAfterRst", gnt0W[0], 1);
        tickAdvance();
        drive0(1'b0, 4'd0, '0, 32'd0);
        drive1(1'b0, 4'd0, '0, 32'd0);
        tick();
        tick();

        // Requester 1 joins a 20-cycle stream from requester 0.
        waitCnt = 0;
        seen1   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive0(1'b1, 4'd0, AW'($urandom_range(16, 31)), 32'd0);
            if (i >= 3 && !seen1) drive1(1'b1, 4'd0, 11'h013, 32'd0);
            else drive1(1'b0, 4'd0, '0, 32'd0);
            tickCheck();
            if (req1) begin
                waitCnt++;
                if (gnt1W[0]) seen1 = 1'b1;
            end
            tickAdvance();
        end
        checkEq("starveSeen", seen1, 1);
        checkEq("starveBound", waitCnt <= 5, 1);
        drive0(1'b0, 4'd0, '0, 32'd0);
        drive1(1'b0, 4'd0, '0, 32'd0);
        tick();

        // Random mixed traffic.
        for (int i = 0; i < 300; i++) begin
            drive0($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0,
                   $urandom_range(0, 1) ? AW'($urandom_range(16, 31)) : AW'($urandom_range(2032, 2047)), $urandom);
            drive1($urandom_range(0, 2) != 0, $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0,
                   $urandom_range(0, 1) ? AW'($urandom_range(16, 31)) : AW'($urandom_range(2032, 2047)), $urandom);
            tick();
        end
        drive0(1'b0, 4'd0, '0, 32'd0);
        drive1(1'b0, 4'd0, '0, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4: maximum consecutive grants to one requester while the other requester is waiting; legal range 1..15.
REQ-002 Parameter AW, default 11: word-address width. This matches the physical word index used by the data and VGA banks.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req0  in  1  requester 0 (CPU load/store path) command valid.
REQ-006 we0  in  4  requester 0 byte write enables; 4'b0000 = read.
REQ-007 addr0  in  AW  requester 0 word address.
REQ-008 wdata0  in  32  requester 0 write data.
REQ-009 gnt0  out  1  requester 0 command accepted this cycle.
REQ-010 rvalid0  out  1  read data for requester 0 valid on rdata.
REQ-011 req1, we1, addr1, wdata1, gnt1, rvalid1: same widths and meaning, for requester 1 (loader/DMA port).
REQ-012 rdata  out  32  shared read-return data.
REQ-013 mem_en  out  1  memory command strobe.
REQ-014 mem_we  out  4  memory byte write enables.
REQ-015 mem_addr  out  AW  memory word address.
REQ-016 mem_wdata  out  32  memory write data.
REQ-017 mem_rdata  in  32  memory read data, valid one clk after a read command (synchronous memory).

Function
REQ-018 FSM states are IDLE, OWN0 and OWN1. A registered last_owner bit and a registered burst counter cnt (4 bits) are held alongside the state.
REQ-019 Winner selection is combinational from the current state, last_owner, cnt, req0 and req1.
  - IDLE, single request: that requester wins.
  - IDLE, both requesting: the requester != last_owner wins.
  - OWNx: x wins if req_x and (!req_other or cnt < BURST_MAX); otherwise the other requester wins if req_other; otherwise there is no winner.
REQ-020 gnt_w = 1 for the winner only, in the same cycle, and gnt is never asserted to both requesters. mem_en=1 and mem_we/mem_addr/mem_wdata = the winner's we/addr/wdata.
REQ-021 With no winner: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, both gnt=0.
REQ-022 Next state is OWNw when there is a winner and IDLE otherwise. last_owner is updated to w on every grant.
REQ-023 cnt becomes 1 on a grant to a new owner, including a grant from IDLE. It increments on a repeated grant to the same owner and saturates at 15.
REQ-024 A granted read (we_w == 0) sets a registered pending flag tagged with w. In the next cycle rvalid_w = 1 and rdata = mem_rdata; at all other times rdata = 0.
REQ-025 A granted write produces no rvalid.
REQ-026 Requesters hold req/we/addr/wdata stable until gnt. Dropping req before gnt is legal and cancels the command.
REQ-027 Back-to-back reads are supported: a new grant may issue in the same cycle that rvalid returns the previous read, so throughput is 1 command/clk.
REQ-028 With BURST_MAX=1 and both requesters continuously active, grants strictly alternate.
REQ-029 Starvation bound: a waiting requester is granted within BURST_MAX+1 cycles of asserting req.

Reset
REQ-030 On rst: state=IDLE, last_owner=1 (so requester 0 wins the first contention), cnt=0, pending cleared.
REQ-031 During and immediately after reset, all outputs are 0.
REQ-032 A read granted in the cycle before rst asserts shall not produce rvalid after reset is released.
REQ-033 rst deassertion takes effect at the next clk edge; no grant is issued while rst=1.

Structure
REQ-034 A shared package holds the FSM state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the constant CNT_W=4.
REQ-035 The block is flat except for one natural sub-module, arb_pick: the combinational winner-selection logic of REQ-019, reusable for the I/O bank.

Verification
REQ-036 Only req0 held, reads at addr 0x010..0x013 -> gnt0 on 4 consecutive cycles; rvalid0 one cycle after each grant with rdata equal to the preloaded words.
REQ-037 Both requesting continuously, BURST_MAX=4, from reset -> grant pattern 0,0,0,0,1,1,1,1,0,... with no idle cycles.
REQ-038 BURST_MAX=1, both requesting -> strict alternation 0,1,0,1; rvalid tags match the issuing requester.
REQ-039 req1 write we1=4'b0011, addr 0x7FF, wdata 0xDEADBEEF, then req0 read of 0x7FF -> mem_we=4'b0011 on the write; the read returns the low half 0xBEEF merged with prior memory contents; no rvalid1.
REQ-040 req0 read granted, rst asserted asynchronously mid-next-cycle -> outputs 0 immediately; no rvalid0 after release; first contention after release goes to requester 0.
REQ-041 req1 asserted while req0 streams for 20 cycles, BURST_MAX=4 -> gnt1 within 5 cycles; gnt0 and gnt1 never both 1.
